ccff_chain_loader: RTL
======================

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 20, meaning the number of configuration flip-flops in the attached ccff chain (range 1..65535).
REQ-002 SHALL have parameter WORD_W, default 8, meaning the width of a configuration data word.
REQ-003 SHALL have parameter ISOL_CYC, default 4, meaning the isolation guard cycles applied before and after shifting (range 1..255).
REQ-004 prog_clk  in  1  the single clock; every register in the block is clocked by its rising edge.
REQ-005 pReset  in  1  reset, asynchronous and active-high.
REQ-006 start  in  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-007 abort  in  1  terminates an in-progress load.
REQ-008 cfg_data  in  WORD_W  configuration word, MSB shifted first.
REQ-009 cfg_valid / cfg_ready  in / out  1 / 1  valid-ready handshake; a word transfers on a cycle with both high.
REQ-010 ccff_head  out  1  serial bit into the chain.
REQ-011 ccff_shift_en  out  1  chain clock enable; the chain advances exactly one bit per cycle with ccff_shift_en=1.
REQ-012 ccff_tail  in  1  serial bit out of the chain.
REQ-013 IO_ISOL_N  out  1  IO isolation, active-low.
REQ-014 busy, done, err  out  1 each  status: load active, load-complete pulse, abort flag.

Function
REQ-015 FSM states SHALL be IDLE, ISOLATE, SHIFT, SETTLE.
REQ-016 IDLE with start=1 SHALL go to ISOLATE next cycle, clear err, drive IO_ISOL_N=0 and busy=1.
REQ-017 ISOLATE SHALL last exactly ISOL_CYC cycles, then go to SHIFT.
REQ-018 In SHIFT, cfg_ready SHALL be 1 only while the internal word buffer is empty.
- Cycle after a transfer: buffer holds WORD_W bits.
REQ-019 Each cycle the buffer is non-empty, the block SHALL:
- drive ccff_head = buffer MSB and ccff_shift_en=1;
- left-shift the buffer;
- increment a bit counter.
REQ-020 With the buffer empty, ccff_shift_en SHALL be 0; the chain holds its state while cfg_valid stalls.
REQ-021 When the bit counter reaches CHAIN_LEN, the block SHALL:
- discard the remaining buffer bits (CHAIN_LEN not a multiple of WORD_W);
- deassert cfg_ready;
- go to SETTLE.
REQ-022 SETTLE SHALL hold IO_ISOL_N=0 for ISOL_CYC cycles.
- Then: pulse done=1 for one cycle, set IO_ISOL_N=1 and busy=0, return to IDLE.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 abort in ISOLATE/SHIFT/SETTLE SHALL, on the next cycle:
- go to IDLE;
- set err=1, busy=0, ccff_shift_en=0, cfg_ready=0;
- keep IO_ISOL_N=0 until a later load completes.
REQ-025 abort has priority over a same-cycle handshake or counter terminal event; the word is dropped and no done pulse is produced.
REQ-026 ccff_head SHALL be 0 whenever ccff_shift_en=0.
REQ-027 The bit counter SHALL be ceil(log2(CHAIN_LEN+1)) bits wide, with no wrap-around within one load.

Reset
REQ-028 While pReset=1, the outputs SHALL be:
- IO_ISOL_N=0;
- ccff_head=0, ccff_shift_en=0, cfg_ready=0;
- busy=0, done=0, err=0;
- state IDLE, counters and buffer cleared.
REQ-029 pReset asserted mid-load SHALL abandon the load immediately without setting err.
REQ-030 After reset release, the block SHALL accept start on the first rising edge.

Configuration
REQ-031 Macro CCFF_READBACK_EN, when defined, SHALL add outputs rb_data (WORD_W) and rb_valid (1).
- Bits sampled from ccff_tail on each shifting cycle assemble MSB-first into rb_data.
- rb_valid pulses one cycle per WORD_W bits collected.
- Any final partial word is left-aligned, zero-padded and emitted when SHIFT ends.
- rb_data and rb_valid reset to 0; there is no backpressure.
REQ-032 Without CCFF_READBACK_EN, rb_data, rb_valid and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Default parameters, start, words 0xA5, 0x3C, 0xF0 sent back-to-back:
- 20 shift cycles with head sequence 1010010100111100 1111; last 4 bits of 0xF0 discarded;
- IO_ISOL_N low from start+1 through SETTLE;
- done one cycle after SETTLE, then IO_ISOL_N=1.
REQ-034 cfg_valid dropped for 5 cycles after the first word: ccff_shift_en=0 for those 5 cycles, and the counter and chain hold.
REQ-035 abort asserted on shift bit 10:
- next cycle err=1, busy=0, IO_ISOL_N=0, no done;
- a following full load clears err and ends with IO_ISOL_N=1.
REQ-036 pReset pulsed during SETTLE: all outputs at reset values, err=0, no done.
REQ-037 With CCFF_READBACK_EN and the chain preloaded with 0x12, 0x34, 0x5:
- rb_valid pulses with 0x12, then 0x34, then 0x50;
- each pulse one cycle after its eighth (or final) bit.
REQ-038 start held high through a whole load: exactly one load runs; a new load starts only from IDLE.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Serial loader for a configuration flip-flop chain, with IO isolation guard bands.
// Define CCFF_READBACK_EN to add rb_data/rb_valid capture of bits leaving the chain tail.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8,
    parameter int ISOL_CYC  = 4
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef CCFF_READBACK_EN
    ,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
`endif
);

    localparam int BCW = $clog2(CHAIN_LEN + 1);
    localparam int WCW = $clog2(WORD_W + 1);

    localparam logic [BCW-1:0] LAST_BIT  = BCW'(CHAIN_LEN - 1);
    localparam logic [WCW-1:0] FULL_WORD = WCW'(WORD_W);
    localparam logic [7:0]     ISOL_LAST = 8'(ISOL_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISOLATE,
        SHIFT,
        SETTLE
    } state_e;

    state_e            state_q;
    logic [BCW-1:0]    bit_cnt_q;
    logic [WCW-1:0]    buf_cnt_q;
    logic [WORD_W-1:0] buf_q;
    logic [7:0]        guard_cnt_q;
    logic              isol_n_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic buf_has;
    logic shifting;
    logic last_bit;
    logic abort_req;

    assign buf_has   = (buf_cnt_q != '0);
    assign shifting  = (state_q == SHIFT) && buf_has;
    assign last_bit  = shifting && (bit_cnt_q == LAST_BIT);
    assign abort_req = abort && (state_q != IDLE);

    // Head is gated so the chain never sees stale buffer bits while stalled.
    assign ccff_shift_en = shifting;
    assign ccff_head     = shifting & buf_q[WORD_W-1];
    assign cfg_ready     = (state_q == SHIFT) && !buf_has;

    assign IO_ISOL_N = isol_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    // NOTE: registers take <= so every branch below reads pre-edge values.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            buf_cnt_q   <= '0;
            buf_q       <= '0;
            guard_cnt_q <= '0;
            isol_n_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_req) begin
                // Isolation stays asserted: the chain content is now incomplete.
                state_q     <= IDLE;
                err_q       <= 1'b1;
                busy_q      <= 1'b0;
                bit_cnt_q   <= '0;
                buf_cnt_q   <= '0;
                buf_q       <= '0;
                guard_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q     <= ISOLATE;
                            err_q       <= 1'b0;
                            isol_n_q    <= 1'b0;
                            busy_q      <= 1'b1;
                            bit_cnt_q   <= '0;
                            guard_cnt_q <= '0;
                        end
                    end
                    ISOLATE: begin
                        if (guard_cnt_q == ISOL_LAST) begin
                            guard_cnt_q <= '0;
                            state_q     <= SHIFT;
                        end else begin
                            guard_cnt_q <= guard_cnt_q + 8'd1;
                        end
                    end
                    SHIFT: begin
                        if (buf_has) begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                            if (last_bit) begin
                                state_q   <= SETTLE;
                                buf_q     <= '0;
                                buf_cnt_q <= '0;
                            end else begin
                                buf_q     <= buf_q << 1;
                                buf_cnt_q <= buf_cnt_q - WCW'(1);
                            end
                        end else if (cfg_valid) begin
                            buf_q     <= cfg_data;
                            buf_cnt_q <= FULL_WORD;
                        end
                    end
                    SETTLE: begin
                        if (guard_cnt_q == ISOL_LAST) begin
                            state_q     <= IDLE;
                            guard_cnt_q <= '0;
                            done_q      <= 1'b1;
                            isol_n_q    <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            guard_cnt_q <= guard_cnt_q + 8'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef CCFF_READBACK_EN
    logic [WCW-1:0]    rb_cnt_q;
    logic [WORD_W-1:0] rb_acc_q;
    logic [WORD_W-1:0] rb_acc_d;
    logic [WORD_W-1:0] rb_data_q;
    logic              rb_valid_q;

    // Each tail bit lands MSB-first, so a short final word comes out left-aligned.
    always_comb begin
        rb_acc_d = rb_acc_q | (WORD_W'(ccff_tail) << (FULL_WORD - WCW'(1) - rb_cnt_q));
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            rb_cnt_q   <= '0;
            rb_acc_q   <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= 1'b0;
            if (abort_req) begin
                rb_cnt_q <= '0;
                rb_acc_q <= '0;
            end else if (shifting) begin
                if ((rb_cnt_q == FULL_WORD - WCW'(1)) || last_bit) begin
                    rb_data_q  <= rb_acc_d;
                    rb_valid_q <= 1'b1;
                    rb_cnt_q   <= '0;
                    rb_acc_q   <= '0;
                end else begin
                    rb_acc_q <= rb_acc_d;
                    rb_cnt_q <= rb_cnt_q + WCW'(1);
                end
            end
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
`else
    logic tail_unused;
    assign tail_unused = ccff_tail;
`endif

endmodule
